// File: rtl/layer_pkg.sv
// Shared types and constants for the video layer priority controller:
// layer indices, the packed priority-order vector, the config FSM states
// and the permutation check used to validate new orders.
package layer_pkg;

  localparam int NUM_LAYERS = 4;
  localparam int LW         = 2;

  typedef logic [LW-1:0] layer_idx_t;

  // Slot i holds the layer drawn at priority i; slot 0 is the highest.
  // Packed so that slot i occupies bits i*LW +: LW of the flat vector.
  typedef layer_idx_t [NUM_LAYERS-1:0] prio_vec_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_t;

  localparam layer_idx_t LAYER_BALL     = 2'd0;
  localparam layer_idx_t LAYER_FLIPPER  = 2'd1;
  localparam layer_idx_t LAYER_SCORE    = 2'd2;
  localparam layer_idx_t LAYER_OBSTACLE = 2'd3;

  localparam prio_vec_t IDENTITY_PRIO =
    {LAYER_OBSTACLE, LAYER_SCORE, LAYER_FLIPPER, LAYER_BALL};

  // An order is legal only if every layer appears exactly once. With
  // NUM_LAYERS slots, that holds exactly when every layer is seen.
  function automatic logic is_permutation(input prio_vec_t p);
    logic [NUM_LAYERS-1:0] seen;
    seen = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      seen[p[i]] = 1'b1;
    end
    return &seen;
  endfunction

endpackage

// File: rtl/layer_prio_select.sv
// Combinational priority encoder: walks the active order from the highest
// slot and reports the first layer that wants to draw and is not masked.
module layer_prio_select
  import layer_pkg::*;
(
  input  logic [NUM_LAYERS*LW-1:0] order,
  input  logic [NUM_LAYERS-1:0]    draw_req,
  input  logic [NUM_LAYERS-1:0]    mask,
  output logic [LW-1:0]            winner,
  output logic                     hit
);

  prio_vec_t ord;
  assign ord = order;

  // Scan lowest priority first so the highest-priority eligible slot
  // overwrites the result last.
  always_comb begin
    winner = '0;
    hit    = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (draw_req[ord[i]] && !mask[ord[i]]) begin
        winner = ord[i];
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_priority_ctrl.sv
// Frame-synchronous layer priority controller. Game logic requests a new
// draw order; the order is validated, held in a shadow register and only
// copied to the active order at start of frame, so a frame never mixes
// orders. Every pixel the active order, draw flags and blink mask pick a
// winning layer, registered for the object mux select.
//
// Config handshake: cfg_req is a single-cycle request sampled only while
// cfg_busy is low. The response comes the next cycle: either cfg_busy rises
// (accepted, waiting for start of frame) or cfg_err pulses for one cycle
// (rejected). An accepted request ends with a one-cycle cfg_ack in the
// cycle after the committing start_of_frame, together with cfg_busy falling.
module layer_priority_ctrl
  import layer_pkg::*;
#(
  parameter int BLINK_FRAMES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_of_frame,
  input  logic                     cfg_req,
  input  logic [NUM_LAYERS*LW-1:0] cfg_prio,
  output logic                     cfg_busy,
  output logic                     cfg_ack,
  output logic                     cfg_err,
  input  logic [NUM_LAYERS-1:0]    blink_en,
  input  logic [NUM_LAYERS-1:0]    draw_req,
  output logic                     sel_valid,
  output logic [LW-1:0]            sel_layer,
  output logic                     blink_phase,
  output logic                     dbg_state
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

  cfg_state_t state, state_next;
  prio_vec_t  active, shadow, req_prio;
  logic       load_shadow, commit, reject;

  logic [CW-1:0]         frame_cnt;
  logic [NUM_LAYERS-1:0] mask;
  logic [LW-1:0]         win_layer;
  logic                  win_hit;

  assign req_prio  = cfg_prio;
  assign cfg_busy  = (state == PENDING);
  assign dbg_state = state;

  // Next-state logic: validate requests in IDLE, commit on frame start in
  // PENDING. A request arriving with start_of_frame in IDLE is only latched;
  // the commit waits for the following frame start.
  always_comb begin
    state_next  = state;
    load_shadow = 1'b0;
    commit      = 1'b0;
    reject      = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_req) begin
          if (is_permutation(req_prio)) begin
            load_shadow = 1'b1;
            state_next  = PENDING;
          end else begin
            reject = 1'b1;
          end
        end
      end
      PENDING: begin
        if (start_of_frame) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Shadow/active order registers and the one-cycle ack/err pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow  <= IDENTITY_PRIO;
      active  <= IDENTITY_PRIO;
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      if (load_shadow) shadow <= req_prio;
      if (commit)      active <= shadow;
      cfg_ack <= commit;
      cfg_err <= reject;
    end
  end

  // Frame counter; blink phase flips each time the counter wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (start_of_frame) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign mask = blink_en & {NUM_LAYERS{blink_phase}};

  layer_prio_select u_select (
    .order    (active),
    .draw_req (draw_req),
    .mask     (mask),
    .winner   (win_layer),
    .hit      (win_hit)
  );

  // Register the per-pixel winner for the mux select.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_valid <= 1'b0;
      sel_layer <= '0;
    end else begin
      sel_valid <= win_hit;
      sel_layer <= win_layer;
    end
  end

endmodule
